// File: rtl/demux_1x8_deser.sv
// demux_1x8_deser: time-division 1-to-8 demultiplexer / byte deserializer.
// Accepts one serial bit per cycle with i_valid high and steps an internal slot
// counter through slots 0..7. The byte being built lives in a staging register.
// The byte is copied to out when the 8th slot is filled, and it is handed off
// with a valid/ready handshake. frame_start resyncs the slot counter to slot 0.
// If a completed byte replaces one that was never consumed, the sticky overrun
// flag is set.
//
// Parameters:
//   LSB_FIRST   - 1: first bit of a frame lands in out[0]; 0: it lands in out[7]
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   i           - serial data bit
//   i_valid     - i is accepted on this rising edge
//   frame_start - sampled only with i_valid; marks the current bit as slot 0
//   out_ready   - consumer accepts out this cycle
//   out         - last completed byte, held until replaced
//   out_valid   - out holds an unconsumed byte
//   sel         - slot index the next accepted bit will occupy
//   overrun     - sticky: a completed byte replaced an unconsumed one
module demux_1x8_deser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i,
  input  logic       i_valid,
  input  logic       frame_start,
  input  logic       out_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [2:0] sel,
  output logic       overrun
);

  logic [7:0] staging_q, staging_d;
  logic [7:0] out_q, out_d;
  logic [2:0] sel_q, sel_d;
  logic       out_valid_q, out_valid_d;
  logic       overrun_q, overrun_d;

  logic [7:0] merged;
  logic [2:0] bit_idx;
  logic [2:0] slot0_idx;
  logic       complete;

  // Physical bit position of the current slot, and of slot 0, in the staging register.
  assign bit_idx   = LSB_FIRST ? sel_q : (3'd7 - sel_q);
  assign slot0_idx = LSB_FIRST ? 3'd0 : 3'd7;

  always_comb begin
    staging_d   = staging_q;
    out_d       = out_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    complete    = 1'b0;
    merged      = staging_q;
    merged[bit_idx] = i;

    if (i_valid) begin
      if (frame_start) begin
        // Resync: any partial byte is dropped silently.
        staging_d            = '0;
        staging_d[slot0_idx] = i;
        sel_d                = 3'd1;
      end else if (sel_q == 3'd7) begin
        complete  = 1'b1;
        out_d     = merged;
        staging_d = '0;
        sel_d     = 3'd0;
      end else begin
        staging_d = merged;
        sel_d     = sel_q + 3'd1;
      end
    end

    if (complete) begin
      // Newest byte always wins; it only counts as overrun if the old byte was not taken.
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q   <= '0;
      out_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      staging_q   <= staging_d;
      out_q       <= out_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Self-checking bench for demux_1x8_deser. One LSB-first instance and one
// MSB-first instance are driven from the same stimulus. A frame-level model
// checks both: it keeps the bits of the current frame in a queue and assembles
// the byte arithmetically once eight bits have been collected.
module tb_demux_1x8_deser;

  logic       clk;
  logic       rst_n;
  logic       i;
  logic       i_valid;
  logic       frame_start;
  logic       out_ready;
  logic [7:0] out_l, out_m;
  logic       out_valid_l, out_valid_m;
  logic [2:0] sel_l, sel_m;
  logic       overrun_l, overrun_m;

  int n_checks;
  int n_fail;

  // Reference model state.
  bit       fq[$];
  bit [7:0] m_out_l, m_out_m;
  bit       m_valid;
  bit       m_ovr;

  demux_1x8_deser #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i           (i),
    .i_valid     (i_valid),
    .frame_start (frame_start),
    .out_ready   (out_ready),
    .out         (out_l),
    .out_valid   (out_valid_l),
    .sel         (sel_l),
    .overrun     (overrun_l)
  );

  demux_1x8_deser #(.LSB_FIRST(1'b0)) dut_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i           (i),
    .i_valid     (i_valid),
    .frame_start (frame_start),
    .out_ready   (out_ready),
    .out         (out_m),
    .out_valid   (out_valid_m),
    .sel         (sel_m),
    .overrun     (overrun_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_out_l = '0;
    m_out_m = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One clock edge of the reference behaviour, taken from the current inputs.
  task automatic model_edge();
    bit done;
    done = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (i_valid) begin
      if (frame_start) begin
        fq.delete();
        fq.push_back(i);
      end else begin
        fq.push_back(i);
        if (fq.size() == 8) begin
          done = 1'b1;
          if (m_valid && !out_ready) m_ovr = 1'b1;
          m_out_l = '0;
          m_out_m = '0;
          for (int k = 0; k < 8; k++) begin
            m_out_l = m_out_l | (8'(fq[k]) << k);
            m_out_m = m_out_m | (8'(fq[k]) << (7 - k));
          end
          m_valid = 1'b1;
          fq.delete();
        end
      end
    end
    if (!done && m_valid && out_ready) m_valid = 1'b0;
  endtask

  task automatic check_all();
    check("out_lsb", 32'(out_l), 32'(m_out_l));
    check("out_msb", 32'(out_m), 32'(m_out_m));
    check("valid_lsb", 32'(out_valid_l), 32'(m_valid));
    check("valid_msb", 32'(out_valid_m), 32'(m_valid));
    check("sel_lsb", 32'(sel_l), 32'(fq.size()));
    check("sel_msb", 32'(sel_m), 32'(fq.size()));
    check("ovr_lsb", 32'(overrun_l), 32'(m_ovr));
    check("ovr_msb", 32'(overrun_m), 32'(m_ovr));
  endtask

  // Inputs are changed 1 ns after an edge, so they are stable at the next edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send_bit(input bit b, input bit fs, input bit rdy);
    i = b; frame_start = fs; i_valid = 1'b1; out_ready = rdy;
    tick();
    i_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    i_valid = 1'b0; frame_start = 1'b0; out_ready = rdy;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Bit k of v is sent k-th, with frame_start on the first bit.
  task automatic send_byte(input logic [7:0] v, input bit rdy, input int gap);
    for (int k = 0; k < 8; k++) begin
      send_bit(v[k], k == 0, rdy);
      if (gap > 0) begin
        if (k < 7) begin
          check("no_early_valid", 32'(out_valid_l), 32'(m_valid));
        end
        idle(gap, rdy);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    idle(2, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i = 1'b0; i_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    idle(2, 1'b0);
    check("reset_out", 32'(out_l), 32'h0);
    rst_n = 1'b1;

    // Bits 1,0,1,1,0,0,1,0: 8'h4D LSB-first, 8'hB2 MSB-first.
    send_byte(8'h4D, 1'b1, 0);
    check("byte_4d", 32'(out_l), 32'h4D);
    check("byte_b2", 32'(out_m), 32'hB2);
    check("pulse_hi", 32'(out_valid_l), 32'h1);
    check("sel_wrap", 32'(sel_l), 32'h0);
    idle(1, 1'b1);
    check("pulse_lo", 32'(out_valid_l), 32'h0);

    // Same stream with 3-cycle gaps between bits.
    send_byte(8'h4D, 1'b1, 3);
    check("gap_4d", 32'(out_l), 32'h4D);

    // Overrun: two bytes with no consumer.
    idle(2, 1'b1);
    send_byte(8'hA5, 1'b0, 0);
    check("ovr_first", 32'(out_l), 32'hA5);
    check("ovr_first_flag", 32'(overrun_l), 32'h0);
    send_byte(8'h3C, 1'b0, 0);
    check("ovr_second", 32'(out_l), 32'h3C);
    check("ovr_second_flag", 32'(overrun_l), 32'h1);
    idle(1, 1'b1);
    check("ovr_consumed", 32'(out_valid_l), 32'h0);
    check("ovr_sticky", 32'(overrun_l), 32'h1);

    // Resync drops the 5-bit partial frame.
    for (int k = 0; k < 5; k++) send_bit(1'($urandom), 1'b0, 1'b1);
    check("partial_none", 32'(out_valid_l), 32'h0);
    send_bit(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) send_bit(1'b1, 1'b0, 1'b1);
    check("resync_ff", 32'(out_l), 32'hFF);
    check("resync_valid", 32'(out_valid_l), 32'h1);
    idle(1, 1'b1);

    // Async reset mid-frame with sel=4 and out_valid=1.
    send_byte(8'h5A, 1'b0, 0);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0, 1'b0);
    check("pre_rst_sel", 32'(sel_l), 32'h4);
    check("pre_rst_valid", 32'(out_valid_l), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_out", 32'(out_l), 32'h0);
    check("async_valid", 32'(out_valid_l), 32'h0);
    check("async_sel", 32'(sel_l), 32'h0);
    check("async_ovr", 32'(overrun_l), 32'h0);
    model_reset();
    idle(1, 1'b0);
    rst_n = 1'b1;
    send_byte(8'hC3, 1'b1, 0);
    check("post_rst_c3", 32'(out_l), 32'hC3);
    check("post_rst_c3_msb", 32'(out_m), 32'hC3);

    // Randomized traffic, compared cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      i           = 1'($urandom);
      i_valid     = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      tick();
      if (n == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
